// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// Single request outstanding; a request completes on inst_req && inst_ready.
interface if_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ready,
    input  inst_rvalid,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ready,
    output inst_rvalid,
    output inst_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Fetch stage: one outstanding memory request feeding a one-entry output slot; fetch latency k>=1 edges.
// pause[0] holds the slot and blocks new requests while it is occupied; flushes redirect the pc.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter logic [31:0] BUBBLE_PC = 32'h100,
  parameter logic [6:0]  EXC_NOP   = 7'h00,
  parameter logic [6:0]  EXC_ADEF  = 7'h08
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    pause,
  input  logic          branch_flush,
  input  logic [31:0]   branch_target,
  input  logic          exception_flush,
  input  logic [31:0]   exception_target,
  if_stage_if.master    mem,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_inst,
  output logic [4:0]    if_is_exception,
  output logic [34:0]   if_exception_cause
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_EXC_HOLD} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        slot_vld_q;
  logic [31:0] slot_pc_q;
  logic [31:0] slot_inst_q;
  logic        slot_exc_q;
  logic [6:0]  slot_cause_q;

  logic        aligned;
  logic        can_fill;
  logic        req;
  logic        accept;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc_d;
  logic        pause_unused;

  assign pause_unused = ^pause[5:1];

  assign aligned  = (pc_q[1:0] == 2'b00);
  assign can_fill = !slot_vld_q || !pause[0];
  // Gated by rst so no request is visible while reset is held.
  assign req      = rst && (state_q == S_REQ) && aligned && can_fill;
  assign accept   = req && mem.inst_ready;
  // A held address error ignores branches; only an exception redirect releases it.
  assign redirect = exception_flush ||
                    (branch_flush && !pause[0] && (state_q != S_EXC_HOLD));
  assign target   = exception_flush ? exception_target : branch_target;
  assign pc_inc_d = pc_q + 32'd4;

  assign mem.inst_req  = req;
  assign mem.inst_addr = pc_q;

  assign if_pc              = slot_vld_q ? slot_pc_q : BUBBLE_PC;
  assign if_inst            = slot_vld_q ? slot_inst_q : 32'h0;
  assign if_is_exception    = slot_vld_q ? {4'b0000, slot_exc_q} : 5'b00000;
  assign if_exception_cause = slot_vld_q ? {{4{EXC_NOP}}, slot_cause_q} : {5{EXC_NOP}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      slot_vld_q   <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_inst_q  <= 32'h0;
      slot_exc_q   <= 1'b0;
      slot_cause_q <= EXC_NOP;
    end else begin
      if (!pause[0]) begin
        slot_vld_q <= 1'b0;
      end
      if (redirect) begin
        pc_q       <= target;
        slot_vld_q <= 1'b0;
        case (state_q)
          S_REQ:             state_q <= accept ? S_DISCARD : S_REQ;
          S_WAIT, S_DISCARD: state_q <= mem.inst_rvalid ? S_REQ : S_DISCARD;
          default:           state_q <= S_REQ;
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (accept) begin
              state_q <= S_WAIT;
            end else if (!aligned && can_fill) begin
              slot_vld_q   <= 1'b1;
              slot_pc_q    <= pc_q;
              slot_inst_q  <= 32'h0;
              slot_exc_q   <= 1'b1;
              slot_cause_q <= EXC_ADEF;
              state_q      <= S_EXC_HOLD;
            end
          end
          S_WAIT: begin
            // The slot is always empty here: it was drained when the request went out.
            if (mem.inst_rvalid) begin
              slot_vld_q   <= 1'b1;
              slot_pc_q    <= pc_q;
              slot_inst_q  <= mem.inst_rdata;
              slot_exc_q   <= 1'b0;
              slot_cause_q <= EXC_NOP;
              pc_q         <= pc_inc_d;
              state_q      <= S_REQ;
            end
          end
          S_DISCARD: begin
            if (mem.inst_rvalid) begin
              state_q <= S_REQ;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against a transaction-level model
// (pending-request queue with stale marks, next fetch address, output slot).
module tb_if_stage;
  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
  localparam logic [31:0] BUBBLE_PC = 32'h100;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          dly;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pause;
  logic        branch_flush;
  logic [31:0] branch_target;
  logic        exception_flush;
  logic [31:0] exception_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  if_is_exception;
  logic [34:0] if_exception_cause;

  if_stage_if bus();

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .pause              (pause),
    .branch_flush       (branch_flush),
    .branch_target      (branch_target),
    .exception_flush    (exception_flush),
    .exception_target   (exception_target),
    .mem                (bus),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .if_is_exception    (if_is_exception),
    .if_exception_cause (if_exception_cause)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_hold;
  bit          m_vld;
  logic [31:0] m_spc;
  logic [31:0] m_sinst;
  bit          m_sexc;
  logic [6:0]  m_scause;
  bit          exp_req;
  int          lat;
  bit          stray;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1e80_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    bus.inst_rvalid = ((q.size() > 0) && (q[0].dly == 0)) || stray;
    bus.inst_rdata  = (q.size() > 0) ? mem_word(q[0].addr) : 32'hdead_beef;
  endtask

  // Compare DUT against the model in the middle of the cycle.
  task automatic sample();
    @(negedge clk);
    exp_req = rst && !m_hold && (q.size() == 0) && (m_pc[1:0] == 2'b00) && (!m_vld || !pause[0]);
    chk("inst_req", bus.inst_req, exp_req);
    if (exp_req) chk("inst_addr", bus.inst_addr, m_pc);
    chk("if_pc", if_pc, m_vld ? m_spc : BUBBLE_PC);
    chk("if_inst", if_inst, m_vld ? m_sinst : 32'h0);
    chk("if_is_exc", if_is_exception, m_vld ? {4'b0, m_sexc} : 5'b0);
    chk("if_cause", if_exception_cause, m_vld ? {28'b0, m_scause} : 35'b0);
  endtask

  // Apply this cycle's events to the model, then step through the clock edge.
  task automatic advance();
    bit          p0, redir, rsp, acc, vld_before, empty_before;
    logic [31:0] tgt, pc_before;
    p0           = pause[0];
    redir        = exception_flush || (branch_flush && !p0 && !m_hold);
    tgt          = exception_flush ? exception_target : branch_target;
    rsp          = bus.inst_rvalid && (q.size() > 0);
    acc          = exp_req && bus.inst_ready;
    vld_before   = m_vld;
    empty_before = (q.size() == 0);
    pc_before    = m_pc;
    if (!p0) m_vld = 0;
    if (redir) begin
      m_vld = 0;
    end else if (rsp && !q[0].stale) begin
      m_vld = 1; m_spc = q[0].addr; m_sinst = mem_word(q[0].addr);
      m_sexc = 0; m_scause = 7'h00; m_pc = q[0].addr + 32'd4;
    end else if (!m_hold && empty_before && (m_pc[1:0] != 2'b00) && (!vld_before || !p0)) begin
      m_vld = 1; m_spc = m_pc; m_sinst = 32'h0; m_sexc = 1; m_scause = 7'h08; m_hold = 1;
    end
    if (rsp) void'(q.pop_front());
    foreach (q[i]) if (q[i].dly > 0) q[i].dly--;
    if (redir) begin
      foreach (q[i]) q[i].stale = 1;
      m_pc = tgt; m_hold = 0;
    end
    if (acc) q.push_back('{pc_before, redir, lat});
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_pc", if_pc, BUBBLE_PC);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_req", bus.inst_req, 1'b0);
    m_pc = RESET_PC; m_vld = 0; m_hold = 0; q.delete();
    stray = 0;
    drive_mem();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    pause = 6'h0; branch_flush = 0; branch_target = 32'h0;
    exception_flush = 0; exception_target = 32'h0;
    bus.inst_ready = 0; bus.inst_rvalid = 0; bus.inst_rdata = 32'h0;
    stray = 0; lat = 0;
    m_spc = 0; m_sinst = 0; m_sexc = 0; m_scause = 0;
    do_reset();

    // First fetch, then hold the slot for three paused cycles.
    bus.inst_ready = 1; lat = 0;
    sample(); chk("first_addr", bus.inst_addr, 32'h1c00_0000); advance();
    sample(); advance();
    pause = 6'h01;
    sample(); chk("r041_pc", if_pc, 32'h1c00_0000); chk("r041_inst", if_inst, 32'h0280_0000); advance();
    repeat (2) begin
      sample(); chk("pause_pc", if_pc, 32'h1c00_0000); chk("pause_req", bus.inst_req, 1'b0); advance();
    end
    pause = 6'h00; lat = 1;
    sample(); chk("resume_req", bus.inst_req, 1'b1); chk("resume_addr", bus.inst_addr, 32'h1c00_0004); advance();

    // Branch while waiting: the late response must be dropped.
    branch_flush = 1; branch_target = 32'h1c00_0100;
    sample(); advance();
    branch_flush = 0;
    sample(); chk("discard_pc", if_pc, BUBBLE_PC); advance();

    // Redirect to a misaligned target in the same cycle the new fetch is offered.
    bus.inst_ready = 0; branch_flush = 1; branch_target = 32'h1c00_0102;
    sample(); chk("redir_addr", bus.inst_addr, 32'h1c00_0100); chk("no_stale", if_pc, BUBBLE_PC); advance();
    branch_flush = 0; bus.inst_ready = 1;
    sample(); chk("adef_noreq", bus.inst_req, 1'b0); advance();
    sample();
    chk("adef_flag", if_is_exception, 5'b00001);
    chk("adef_cause", if_exception_cause[6:0], 7'h08);
    chk("adef_pc", if_pc, 32'h1c00_0102);
    advance();
    branch_flush = 1; branch_target = 32'h1c00_0200;
    sample(); chk("hold_br_noreq", bus.inst_req, 1'b0); advance();
    branch_flush = 0;
    sample(); chk("hold_noreq", bus.inst_req, 1'b0); advance();

    // Simultaneous exception and branch redirect.
    exception_flush = 1; exception_target = 32'h1c00_8000;
    branch_flush = 1; branch_target = 32'h1c00_0100;
    sample(); advance();
    exception_flush = 0; branch_flush = 0; lat = 3;
    sample(); chk("exc_win_addr", bus.inst_addr, 32'h1c00_8000); advance();
    sample(); advance();

    // Reset in the middle of an outstanding fetch, then a stray response.
    do_reset();
    bus.inst_ready = 0; stray = 1; drive_mem();
    sample(); chk("restart_addr", bus.inst_addr, 32'h1c00_0000); advance();
    stray = 0; drive_mem();
    bus.inst_ready = 1; lat = 0;
    sample(); chk("stray_pc", if_pc, BUBBLE_PC); advance();
    sample(); advance();
    sample(); chk("restart_inst", if_inst, 32'h0280_0000); advance();

    for (int n = 0; n < 800; n++) begin
      int r;
      pause = 6'($urandom);
      pause[0] = ($urandom_range(0, 3) == 0);
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      branch_flush = (r < 10);
      branch_target = ($urandom & 32'hffff_fffc) | ((r < 2) ? 32'h2 : 32'h0);
      exception_flush = ($urandom_range(0, 99) < 5);
      exception_target = $urandom & 32'hffff_fffc;
      sample(); advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1c00_0000, first fetch address after reset.
REQ-002 Parameter BUBBLE_PC, default 32'h100, PC presented when no valid instruction is held.
REQ-003 Parameter EXC_NOP, default 7'h00, cause code meaning no exception.
REQ-004 Parameter EXC_ADEF, default 7'h08, cause code for fetch address error.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pause  in  6  ctrl stall vector; bit 0 holds the IF output slot.
REQ-008 branch_flush  in  1  branch redirect request.
REQ-009 branch_target  in  32  branch redirect address.
REQ-010 exception_flush  in  1  exception/ertn redirect request.
REQ-011 exception_target  in  32  exception redirect address.
REQ-012 inst_req  out  1  instruction memory request valid.
REQ-013 inst_addr  out  32  request address.
REQ-014 inst_ready  in  1  memory accepts the request this cycle.
REQ-015 inst_rvalid  in  1  read data valid.
REQ-016 inst_rdata  in  32  read data.
REQ-017 if_pc  out  32  PC to if_id.
REQ-018 if_inst  out  32  instruction to if_id.
REQ-019 if_is_exception  out  5  per-stage exception flags; bit 0 = IF.
REQ-020 if_exception_cause  out  35  five 7-bit cause slots, slot i at [7i+6:7i]; slot 0 = IF.

Function
REQ-021 Exactly one memory request outstanding at most; a request completes on inst_req && inst_ready.
REQ-022 A one-entry output slot (valid, pc, inst, flags, cause) drives if_* outputs.
REQ-023 Slot empty -> if_pc=BUBBLE_PC, if_inst=0, if_is_exception=0, all cause slots EXC_NOP.
REQ-024 FSM states: REQ, WAIT, DISCARD, EXC_HOLD.
REQ-025 REQ, pc[1:0]==0: inst_req=1, inst_addr=pc, only when slot empty or pause[0]=0; accepted -> WAIT.
REQ-026 REQ, pc[1:0]!=0: no request; slot <- {pc, 0, flag bit0=1, slot0=EXC_ADEF}; -> EXC_HOLD.
REQ-027 WAIT, inst_rvalid: slot <- {pc, inst_rdata, no exception}; pc <= pc+4 (32-bit wrap); -> REQ.
REQ-028 DISCARD, inst_rvalid: data dropped, slot unchanged; -> REQ.
REQ-029 EXC_HOLD: no requests; leaves only on exception_flush.
REQ-030 Slot consumed on any edge with pause[0]=0; it is cleared unless refilled on the same edge.
REQ-031 Slot held unchanged while pause[0]=1.
REQ-032 exception_flush acts regardless of pause; branch_flush acts only when pause[0]=0; exception_flush wins if both.
REQ-033 Redirect: pc <= target, slot cleared. Next state DISCARD if a request is outstanding (WAIT without rvalid, or REQ accepted same edge); otherwise REQ.
REQ-034 Redirect with inst_rvalid in WAIT: response dropped, next state REQ, pc <= target.
REQ-035 Redirect in DISCARD without rvalid: stay DISCARD, pc <= target. With rvalid: -> REQ.
REQ-036 inst_addr equals pc whenever inst_req=1; inst_addr is don't-care otherwise.
REQ-037 Fetch latency: request accepted at edge N, rvalid at edge N+k -> slot valid after edge N+k, k>=1.

Reset
REQ-038 rst low asynchronously: pc=RESET_PC, state=REQ, slot empty, inst_req=0, outputs show bubble per REQ-023.
REQ-039 Reset asserted mid-transaction discards the outstanding request; any later stray rvalid arriving in REQ is ignored.
REQ-040 First inst_req is asserted in the first cycle after rst deasserts.

Verification
REQ-041 Reset release, inst_ready=1, rvalid one cycle later with rdata=32'h0280_0000 -> if_pc=32'h1c00_0000, if_inst=32'h0280_0000; next inst_addr=32'h1c00_0004.
REQ-042 pause[0]=1 for 3 cycles while slot is valid -> outputs stable, no new inst_req; release -> slot consumed, fetch resumes at pc+4.
REQ-043 branch_flush target 32'h1c00_0100 while in WAIT, rvalid 2 cycles later -> that data dropped; next inst_addr=32'h1c00_0100; no stale instruction is output.
REQ-044 exception_flush and branch_flush in the same cycle (targets 32'h1c00_8000 / 32'h1c00_0100) -> pc=32'h1c00_8000.
REQ-045 branch_target=32'h1c00_0102 -> no inst_req; if_is_exception=5'b00001, cause[6:0]=7'h08, if_pc=32'h1c00_0102; fetch stays held until exception_flush.
REQ-046 rst asserted while in WAIT -> outputs bubble immediately (BUBBLE_PC, inst 0); after release, fetch restarts at 32'h1c00_0000.
